// File: rtl/iob_ptfloat_unpack_pkg.sv
// Shared PT-float width macros plus FSM encodings for iob_ptfloat_unpack.
// The macro block matches the shared iob_ptfloat_defs.vh definitions and is
// include-guarded with the same guard name, so either source may come first.
`ifndef IOB_PTFLOAT_DEFS_VH
`define IOB_PTFLOAT_DEFS_VH
`define EXP_MAX_W 16
`define MAN_MAX_W 28
`define EXP_MIN   (-32768)
`endif

package iob_ptfloat_unpack_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/iob_sext.sv
// Sign extension of a field whose width is only known at run time.
// width_i = 0 yields zero; bit width_i-1 is the sign bit otherwise.
module iob_sext #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SEL_W = 5
) (
    input  logic [IN_W-1:0]  data_i,
    input  logic [SEL_W-1:0] width_i,
    output logic [OUT_W-1:0] data_o
);

    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] mask;
    logic [OUT_W-1:0] sign_mask;
    logic             sign;

    // Build a low-bit mask of the field, pick its top bit as sign, fill above.
    always_comb begin
        ext       = OUT_W'(data_i);
        mask      = (OUT_W'(1) << width_i) - OUT_W'(1);
        sign_mask = mask ^ (mask >> 1);
        sign      = |(ext & sign_mask);
        data_o    = sign ? (ext | ~mask) : (ext & mask);
    end

endmodule

// File: rtl/iob_ptfloat_unpack.sv
// Serial unpacker for PT-float words {ew, exp[ew], man}: shifts the exponent
// out of the payload one bit per enabled cycle, then presents a sign-extended
// exponent and an MSB-aligned mantissa for one done_o pulse.
// Optional: define IOB_PTFLOAT_UNPACK_SPECIAL_EN for zero_o / nan_o flags.
module iob_ptfloat_unpack
    import iob_ptfloat_unpack_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned EW_W   = 4
) (
    input  logic                         clk_i,
    input  logic                         arst_n_i,
    input  logic                         cke_i,
    input  logic                         start_i,
    input  logic [DATA_W-1:0]            data_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic signed [`EXP_MAX_W-1:0] exp_o,
    output logic [`MAN_MAX_W-1:0]        man_o
`ifdef IOB_PTFLOAT_UNPACK_SPECIAL_EN
    ,
    output logic                         zero_o,
    output logic                         nan_o
`endif
);

    localparam int unsigned MW      = DATA_W - EW_W;
    localparam int unsigned CNT_W   = $clog2(MW + 1);
    localparam int unsigned XW      = `EXP_MAX_W;
    localparam int unsigned MAN_W   = `MAN_MAX_W;
    localparam int unsigned MAN_PAD = MAN_W - MW;

    state_e            state_q, state_d;
    logic [MW-1:0]     shreg_q, shreg_d;
    logic [XW-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  ew_q, ew_d;
    logic [XW-1:0]     exp_q, exp_d;
    logic [MAN_W-1:0]  man_q, man_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef IOB_PTFLOAT_UNPACK_SPECIAL_EN
    logic              zero_q, zero_d;
    logic              nan_q, nan_d;
`endif

    logic [EW_W-1:0]   ew_raw;
    logic [CNT_W-1:0]  ew_sat;
    logic [XW-1:0]     exp_ext;
    logic [MAN_W-1:0]  man_al;

    // Exponent widths beyond the payload consume the whole payload.
    always_comb begin
        ew_raw = data_i[DATA_W-1 -: EW_W];
        ew_sat = (32'(ew_raw) > MW) ? CNT_W'(MW) : CNT_W'(ew_raw);
        man_al = MAN_W'(shreg_q) << MAN_PAD;
    end

    iob_sext #(
        .IN_W  (XW),
        .OUT_W (XW),
        .SEL_W (CNT_W)
    ) u_sext (
        .data_i  (acc_q),
        .width_i (ew_q),
        .data_o  (exp_ext)
    );

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ew_d    = ew_q;
        exp_d   = exp_q;
        man_d   = man_q;
        done_d  = 1'b0;
`ifdef IOB_PTFLOAT_UNPACK_SPECIAL_EN
        zero_d  = zero_q;
        nan_d   = nan_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    shreg_d = data_i[MW-1:0];
                    cnt_d   = ew_sat;
                    ew_d    = ew_sat;
                    acc_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    shreg_d = {shreg_q[MW-2:0], 1'b0};
                    acc_d   = {acc_q[XW-2:0], shreg_q[MW-1]};
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    exp_d   = exp_ext;
                    man_d   = man_al;
`ifdef IOB_PTFLOAT_UNPACK_SPECIAL_EN
                    zero_d  = (shreg_q == '0);
                    nan_d   = (shreg_q == {1'b1, {(MW-1){1'b0}}}) && (ew_q != '0) &&
                              (acc_q == XW'((XW'(1) << ew_q) - XW'(1)));
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; everything holds while cke_i is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ew_q    <= '0;
            exp_q   <= '0;
            man_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef IOB_PTFLOAT_UNPACK_SPECIAL_EN
            zero_q  <= 1'b0;
            nan_q   <= 1'b0;
`endif
        end else if (cke_i) begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ew_q    <= ew_d;
            exp_q   <= exp_d;
            man_q   <= man_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef IOB_PTFLOAT_UNPACK_SPECIAL_EN
            zero_q  <= zero_d;
            nan_q   <= nan_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign exp_o  = exp_q;
    assign man_o  = man_q;
`ifdef IOB_PTFLOAT_UNPACK_SPECIAL_EN
    assign zero_o = zero_q;
    assign nan_o  = nan_q;
`endif

endmodule

// File: tb/tb_iob_ptfloat_unpack.sv
// Directed bench for iob_ptfloat_unpack: a vector table on the default
// 32/4 instance plus a narrow 12/4 instance for exponent-width saturation.
module tb_iob_ptfloat_unpack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         arst_n;
    logic                         cke;
    logic                         start_a, start_b;
    logic [31:0]                  data_a;
    logic [11:0]                  data_b;
    logic                         busy_a, done_a, busy_b, done_b;
    logic signed [`EXP_MAX_W-1:0] exp_a, exp_b;
    logic [`MAN_MAX_W-1:0]        man_a, man_b;
`ifdef IOB_PTFLOAT_UNPACK_SPECIAL_EN
    logic                         zero_a, nan_a, zero_b, nan_b;
`endif

    iob_ptfloat_unpack #(.DATA_W(32), .EW_W(4)) dut_a (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .cke_i    (cke),
        .start_i  (start_a),
        .data_i   (data_a),
        .busy_o   (busy_a),
        .done_o   (done_a),
        .exp_o    (exp_a),
        .man_o    (man_a)
`ifdef IOB_PTFLOAT_UNPACK_SPECIAL_EN
        ,
        .zero_o   (zero_a),
        .nan_o    (nan_a)
`endif
    );

    iob_ptfloat_unpack #(.DATA_W(12), .EW_W(4)) dut_b (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .cke_i    (cke),
        .start_i  (start_b),
        .data_i   (data_b),
        .busy_o   (busy_b),
        .done_o   (done_b),
        .exp_o    (exp_b),
        .man_o    (man_b)
`ifdef IOB_PTFLOAT_UNPACK_SPECIAL_EN
        ,
        .zero_o   (zero_b),
        .nan_o    (nan_b)
`endif
    );

    typedef struct {
        logic [31:0]        data;
        int                 lat;
        logic signed [15:0] exp;
        logic [27:0]        man;
        logic               zero;
        logic               nan;
    } vec_t;

    vec_t vecs [8];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Pulse start for one edge; returns #1 after the sampling edge (edge count 1).
    task automatic launch(input bit sel, input logic [31:0] d);
        @(negedge clk);
        if (sel) begin start_b = 1'b1; data_b = d[11:0]; end
        else     begin start_a = 1'b1; data_a = d;       end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Bounded wait for done; lat is the edge count at which done is seen, -1 on timeout.
    task automatic wait_done(input bit sel, input int n0, output int lat);
        int n;
        n   = n0;
        lat = -1;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            if (sel ? done_b : done_a) begin
                lat = n;
                break;
            end
        end
    endtask

    // One edge past done: pulse must have ended and the unit must be idle.
    task automatic finish_op(input bit sel, input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, longint'(sel ? done_b : done_a), 0);
        chk({tag, "_busy_drop"}, longint'(sel ? busy_b : busy_a), 0);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (done_a) cnt++;
        end
    endtask

    initial begin
        int lat;
        int cnt;

        vecs[0] = '{32'h4A12_3456, 6,  16'shFFFA, 28'h123_4560, 1'b0, 1'b0};
        vecs[1] = '{32'h0400_0000, 2,  16'sh0000, 28'h400_0000, 1'b0, 1'b0};
        vecs[2] = '{32'h37AB_CDEF, 5,  16'sh0003, 28'hD5E_6F78, 1'b0, 1'b0};
        vecs[3] = '{32'hF800_0001, 17, 16'shC000, 28'h000_8000, 1'b0, 1'b0};
        vecs[4] = '{32'h1FFF_FFFF, 3,  16'shFFFF, 28'hFFF_FFFE, 1'b0, 1'b0};
        vecs[5] = '{32'h4F80_0000, 6,  16'shFFFF, 28'h800_0000, 1'b0, 1'b1};
        vecs[6] = '{32'h4200_0000, 6,  16'sh0002, 28'h000_0000, 1'b1, 1'b0};
        vecs[7] = '{32'h0000_0000, 2,  16'sh0000, 28'h000_0000, 1'b1, 1'b0};

        arst_n  = 1'b0;
        cke     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        data_a  = '0;
        data_b  = '0;
        #1;
        chk("rst_busy", longint'(busy_a), 0);
        chk("rst_done", longint'(done_a), 0);
        chk("rst_exp",  longint'(exp_a),  0);
        chk("rst_man",  longint'(man_a),  0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;

        // Table-driven vectors on the default instance.
        for (int i = 0; i < 8; i++) begin
            launch(1'b0, vecs[i].data);
            chk($sformatf("v%0d_busy", i), longint'(busy_a), 1);
            wait_done(1'b0, 1, lat);
            chk($sformatf("v%0d_lat", i), longint'(lat), longint'(vecs[i].lat));
            chk($sformatf("v%0d_exp", i), longint'(exp_a), longint'(vecs[i].exp));
            chk($sformatf("v%0d_man", i), longint'(man_a), longint'(vecs[i].man));
`ifdef IOB_PTFLOAT_UNPACK_SPECIAL_EN
            chk($sformatf("v%0d_zero", i), longint'(zero_a), longint'(vecs[i].zero));
            chk($sformatf("v%0d_nan", i),  longint'(nan_a),  longint'(vecs[i].nan));
`endif
            finish_op(1'b0, $sformatf("v%0d", i));
        end

        // Second start during an op is dropped.
        launch(1'b0, vecs[0].data);
        @(posedge clk); #1;
        data_a  = 32'h0400_0000;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_done(1'b0, 3, lat);
        chk("ign_lat", longint'(lat), 6);
        chk("ign_exp", longint'(exp_a), longint'(vecs[0].exp));
        chk("ign_man", longint'(man_a), longint'(vecs[0].man));
        count_dones(10, cnt);
        chk("ign_extra_done", longint'(cnt), 0);
        chk("ign_busy", longint'(busy_a), 0);

        // Asynchronous reset mid-SHIFT aborts without done.
        launch(1'b0, vecs[0].data);
        @(posedge clk); #1;
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk("arst_busy", longint'(busy_a), 0);
        chk("arst_done", longint'(done_a), 0);
        chk("arst_exp",  longint'(exp_a),  0);
        chk("arst_man",  longint'(man_a),  0);
        @(negedge clk);
        arst_n = 1'b1;
        count_dones(10, cnt);
        chk("arst_no_done", longint'(cnt), 0);
        launch(1'b0, vecs[2].data);
        wait_done(1'b0, 1, lat);
        chk("arst_next_lat", longint'(lat), 5);
        chk("arst_next_exp", longint'(exp_a), longint'(vecs[2].exp));
        chk("arst_next_man", longint'(man_a), longint'(vecs[2].man));
        finish_op(1'b0, "arst_next");

        // Clock enable low for 3 cycles mid-SHIFT stretches latency by 3.
        launch(1'b0, vecs[0].data);
        @(posedge clk); #1;
        cke = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        chk("cke_busy_hold", longint'(busy_a), 1);
        cke = 1'b1;
        wait_done(1'b0, 5, lat);
        chk("cke_lat", longint'(lat), 9);
        chk("cke_exp", longint'(exp_a), longint'(vecs[0].exp));
        chk("cke_man", longint'(man_a), longint'(vecs[0].man));
        finish_op(1'b0, "cke");

        // Results hold in IDLE until the next DONE.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        chk("hold_exp", longint'(exp_a), longint'(vecs[0].exp));
        chk("hold_man", longint'(man_a), longint'(vecs[0].man));

        // Narrow instance: ew=15 saturates to the 8-bit payload.
        launch(1'b1, 32'h0000_0FA5);
        chk("sat_busy", longint'(busy_b), 1);
        wait_done(1'b1, 1, lat);
        chk("sat_lat", longint'(lat), 10);
        chk("sat_exp", longint'(exp_b), longint'(16'shFFA5));
        chk("sat_man", longint'(man_b), 0);
`ifdef IOB_PTFLOAT_UNPACK_SPECIAL_EN
        chk("sat_zero", longint'(zero_b), 1);
        chk("sat_nan",  longint'(nan_b),  0);
`endif
        finish_op(1'b1, "sat");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/iob_ptfloat_unpack.md
IOB_PTFLOAT_UNPACK -- requirements
Module: iob_ptfloat_unpack

Interface
REQ-001 SHALL have parameter DATA_W, default 32: packed PT-float word width.
REQ-002 SHALL have parameter EW_W, default 4: exponent-width field width.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port arst_n_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cke_i, input, 1: clock enable; when low, all state holds.
REQ-006 SHALL have port start_i, input, 1: one-cycle request to unpack data_i.
REQ-007 SHALL have port data_i, input, DATA_W: packed word, layout {ew[EW_W], exp[ew], man[rest]}, MSB first.
REQ-008 SHALL have port busy_o, output, 1: unpack in progress.
REQ-009 SHALL have port done_o, output, 1: one-cycle pulse, results valid.
REQ-010 SHALL have port exp_o, output, `EXP_MAX_W, signed: unpacked exponent, sign-extended.
REQ-011 SHALL have port man_o, output, `MAN_MAX_W: two's-complement mantissa, MSB-aligned, zero-padded at LSBs.

Function
REQ-012 SHALL use FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE: on start_i=1 and cke_i=1, SHALL latch data_i[DATA_W-EW_W-1:0] into a shift register, latch ew=data_i[DATA_W-1 -: EW_W] into a down-counter, clear exponent accumulator, go to SHIFT.
REQ-014 SHIFT: each enabled cycle with counter>0, SHALL shift the register left by 1, shift its MSB into the exponent accumulator LSB, decrement counter.
REQ-015 SHIFT with counter==0 SHALL go to DONE.
REQ-016 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-017 Latency start_i to done_o SHALL be ew+2 enabled cycles (ew=0 -> 2).
REQ-018 exp_o SHALL equal the ew-bit exponent sign-extended (bit ew-1 as sign); ew=0 SHALL yield exp_o=0.
REQ-019 man_o SHALL equal the shift register contents after ew shifts (mantissa MSB-aligned, ew zeros at LSBs).
REQ-020 ew > DATA_W-EW_W SHALL saturate to DATA_W-EW_W (mantissa all zero).
REQ-021 busy_o SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-022 start_i while busy_o=1 SHALL be ignored; no queuing.
REQ-023 exp_o/man_o SHALL hold their last values from DONE until the next DONE.

Reset
REQ-024 arst_n_i low SHALL immediately force IDLE, busy_o=0, done_o=0, exp_o=0, man_o=0, counter=0.
REQ-025 Reset mid-SHIFT SHALL abort the operation with no done_o pulse.

Configuration
REQ-026 Macro IOB_PTFLOAT_UNPACK_SPECIAL_EN, when defined, SHALL add outputs zero_o and nan_o (1 bit each), valid with done_o, reset 0.
REQ-027 With the macro: zero_o=1 iff mantissa field is all zero; nan_o=1 iff mantissa is 1 followed by all zeros (most-negative) and exponent is all ones.
REQ-028 Without the macro: the ports and detection logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 `EXP_MAX_W, `MAN_MAX_W, `EXP_MIN SHALL come from the shared iob_ptfloat_defs.vh; FSM state encodings SHALL be local parameters.
REQ-030 Sign extension SHALL be a sub-module iob_sext (parameterised input/output widths).

Verification (DATA_W=32, EW_W=4)
REQ-031 data_i=0x4_A_xxxxxx with ew=4, exp=0b1010 -> done_o at cycle 6, exp_o=-6, man_o=data_i[23:0]<<4.
REQ-032 ew=0, data_i=0x0_4000000 -> done_o at cycle 2, exp_o=0, man_o=0x4000000.
REQ-033 start_i pulsed again at cycle 2 of an ew=4 op -> ignored, single done_o, outputs from first word.
REQ-034 arst_n_i low during SHIFT -> busy_o=0 immediately, no done_o, next start works normally.
REQ-035 cke_i low for 3 cycles mid-SHIFT -> latency extended by exactly 3, results unchanged.
REQ-036 SPECIAL_EN, mantissa field 0 -> zero_o=1 with done_o; mantissa 0x800000, exp all ones -> nan_o=1.
